frame_min_reducer: RTL and testbench

Streaming reducer that sits directly upstream of the min-value compare function's consumers. It accepts a stream of unsigned samples over a valid/ready handshake and groups them into fixed-length frames. For each frame it emits the minimum value and the in-frame index of its first occurrence. It reuses the team's two-input minimum compare as its per-sample datapath.

---
 rtl/min_pkg.sv | 19 +
 rtl/min2_sel.sv | 25 ++
 rtl/frame_min_reducer.sv | 133 +++++++++++++
 tb/tb_frame_min_reducer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/min_pkg.sv
// Shared types and the single "minimum" definition used by every min compare path.
package min_pkg;

    localparam int unsigned DATA_W_DFLT = 8;
    localparam int unsigned MIN_MAX_W   = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    // Unsigned minimum; strict less-than so equal operands return a.
    function automatic logic [MIN_MAX_W-1:0] min_val(input logic [MIN_MAX_W-1:0] a,
                                                     input logic [MIN_MAX_W-1:0] b);
        return (b < a) ? b : a;
    endfunction

endpackage

// File: rtl/min2_sel.sv
// Two-input unsigned minimum with index; ties select a.
module min2_sel
    import min_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DFLT,
    parameter int unsigned IDX_W  = 3
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [IDX_W-1:0]  a_idx,
    input  logic [IDX_W-1:0]  b_idx,
    output logic [DATA_W-1:0] min_c,
    output logic [IDX_W-1:0]  idx_c
);

    logic [MIN_MAX_W-1:0] min_wide;

    // b only wins when the shared minimum differs from a, i.e. b is strictly smaller.
    always_comb begin
        min_wide = min_val(MIN_MAX_W'(a), MIN_MAX_W'(b));
        min_c    = DATA_W'(min_wide);
        idx_c    = (min_c != a) ? b_idx : a_idx;
    end

endmodule

// File: rtl/frame_min_reducer.sv
// Groups a valid/ready sample stream into fixed-length frames and emits each
// frame's minimum and the index of its first occurrence.
module frame_min_reducer
    import min_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DFLT,
    parameter int unsigned FRAME_LEN = 8,
    parameter int unsigned IDX_W     = $clog2(FRAME_LEN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_min,
    output logic [IDX_W-1:0]  out_idx,
    output logic              busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   acc_min_q, acc_min_d;
    logic [IDX_W-1:0]    acc_idx_q, acc_idx_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_min_q, out_min_d;
    logic [IDX_W-1:0]    out_idx_q, out_idx_d;
    logic [DATA_W-1:0]   cmp_min_c;
    logic [IDX_W-1:0]    cmp_idx_c;
    logic                accept_c;

    min2_sel #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_min2_sel (
        .a     (acc_min_q),
        .b     (in_data),
        .a_idx (acc_idx_q),
        .b_idx (cnt_q),
        .min_c (cmp_min_c),
        .idx_c (cmp_idx_c)
    );

    // in_ready is a pure state decode, so a held result always blocks input.
    assign in_ready  = (state_q != ST_HOLD);
    assign busy      = (state_q == ST_ACCUM);
    assign accept_c  = in_valid && in_ready && !clr;
    assign out_valid = out_valid_q;
    assign out_min   = out_min_q;
    assign out_idx   = out_idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            acc_min_q   <= '0;
            acc_idx_q   <= '0;
            out_valid_q <= 1'b0;
            out_min_q   <= '0;
            out_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_min_q   <= acc_min_d;
            acc_idx_q   <= acc_idx_d;
            out_valid_q <= out_valid_d;
            out_min_q   <= out_min_d;
            out_idx_q   <= out_idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) state_d = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (clr)                                   state_d = ST_IDLE;
                else if (accept_c && (cnt_q == LAST_IDX))  state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        acc_min_d   = acc_min_q;
        acc_idx_d   = acc_idx_q;
        out_valid_d = out_valid_q;
        out_min_d   = out_min_q;
        out_idx_d   = out_idx_q;
        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (clr) begin
                    cnt_d     = '0;
                    acc_min_d = '0;
                    acc_idx_d = '0;
                end else if (accept_c && (state_q == ST_IDLE)) begin
                    cnt_d     = IDX_W'(1);
                    acc_min_d = in_data;
                    acc_idx_d = '0;
                end else if (accept_c && (cnt_q == LAST_IDX)) begin
                    // Closing sample: publish result and clear the accumulator.
                    out_valid_d = 1'b1;
                    out_min_d   = cmp_min_c;
                    out_idx_d   = cmp_idx_c;
                    cnt_d       = '0;
                    acc_min_d   = '0;
                    acc_idx_d   = '0;
                end else if (accept_c) begin
                    cnt_d     = cnt_q + IDX_W'(1);
                    acc_min_d = cmp_min_c;
                    acc_idx_d = cmp_idx_c;
                end
            end
            ST_HOLD: begin
                if (out_ready) out_valid_d = 1'b0;
            end
            default: begin
                out_valid_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_frame_min_reducer.sv
// Directed bench for frame_min_reducer with a result scoreboard.
module tb_frame_min_reducer;

    localparam int unsigned DW = 8;
    localparam int unsigned FL = 8;
    localparam int unsigned IW = 3;

    typedef struct packed {
        logic [DW-1:0] min;
        logic [IW-1:0] idx;
    } result_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_min;
    logic [IW-1:0] out_idx;
    logic          busy;

    result_t       sb_q[$];
    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] f[FL];

    frame_min_reducer #(
        .DATA_W    (DW),
        .FRAME_LEN (FL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_min   (out_min),
        .out_idx   (out_idx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Feed n samples without a scoreboard entry (frame expected to be discarded).
    task automatic feed_raw(input logic [DW-1:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = v;
            step();
        end
        in_valid = 1'b0;
    endtask

    // Drive one full frame; the bench model computes the expected result up front.
    task automatic send_frame(input logic [DW-1:0] v[FL], input int gap);
        result_t exp;
        exp.min = v[0];
        exp.idx = '0;
        for (int i = 1; i < FL; i++) begin
            if (v[i] < exp.min) begin
                exp.min = v[i];
                exp.idx = IW'(i);
            end
        end
        sb_q.push_back(exp);
        for (int i = 0; i < FL; i++) begin
            chk("in_ready_accum", 32'(in_ready), 32'd1);
            in_valid = 1'b1;
            in_data  = v[i];
            step();
            in_valid = 1'b0;
            if (i < FL - 1) begin
                chk("busy_mid", 32'(busy), 32'd1);
                for (int g = 0; g < gap; g++) begin
                    step();
                    chk("busy_gap", 32'(busy), 32'd1);
                end
            end
        end
        chk("out_valid_latency", 32'(out_valid), 32'd1);
        chk("busy_after_close", 32'(busy), 32'd0);
    endtask

    task automatic expect_result(output result_t exp);
        int t;
        t = 0;
        while (!out_valid && t < 20) begin
            step();
            t++;
        end
        chk("out_valid_wait", 32'(out_valid), 32'd1);
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 32'(sb_q.size()), 32'd1);
            exp = '0;
        end else begin
            exp = sb_q.pop_front();
            chk("out_min", 32'(out_min), 32'(exp.min));
            chk("out_idx", 32'(out_idx), 32'(exp.idx));
        end
    endtask

    // out_ready high: exactly one blocked cycle, then idle and ready.
    task automatic finish_frame();
        result_t exp;
        expect_result(exp);
        chk("in_ready_hold", 32'(in_ready), 32'd0);
        step();
        chk("out_valid_drop", 32'(out_valid), 32'd0);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
    endtask

    initial begin
        result_t exp;
        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_min", 32'(out_min), 32'd0);
        chk("rst_out_idx", 32'(out_idx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        step();

        // Basic frame with repeated minimum: first 12 wins.
        f = '{8'd23, 8'd45, 8'd100, 8'd55, 8'd12, 8'd200, 8'd12, 8'd99};
        send_frame(f, 0);
        finish_frame();

        // Asynchronous reset in the middle of a frame.
        feed_raw(8'd1, 3);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_out_min", 32'(out_min), 32'd0);
        chk("mid_rst_out_idx", 32'(out_idx), 32'd0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        step();
        rst_n = 1'b1;
        step();
        f = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2};
        send_frame(f, 0);
        finish_frame();

        // Backpressure with a clr attempt that must be ignored in HOLD.
        out_ready = 1'b0;
        f = '{default: 8'd255};
        send_frame(f, 0);
        expect_result(exp);
        for (int c = 0; c < 5; c++) begin
            clr = (c == 2);
            step();
            clr = 1'b0;
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_min", 32'(out_min), 32'(exp.min));
            chk("bp_out_idx", 32'(out_idx), 32'(exp.idx));
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_ready", 32'(in_ready), 32'd1);

        // Bubbles: in_valid every other cycle.
        f = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
        send_frame(f, 1);
        finish_frame();

        // clr colliding with a valid sample after a partial frame.
        feed_raw(8'd1, 4);
        in_valid = 1'b1;
        in_data  = 8'd0;
        clr      = 1'b1;
        chk("clr_in_ready", 32'(in_ready), 32'd1);
        step();
        clr      = 1'b0;
        in_valid = 1'b0;
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_out_valid", 32'(out_valid), 32'd0);
        f = '{8'd50, 8'd40, 8'd30, 8'd20, 8'd10, 8'd60, 8'd70, 8'd80};
        send_frame(f, 0);
        finish_frame();

        // Back-to-back frames with out_ready held high.
        f = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        send_frame(f, 0);
        finish_frame();
        f = '{8'd0, 8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd0};
        send_frame(f, 0);
        finish_frame();

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
